// File: rtl/audio_sample_streamer_pkg.sv
// Shared types and constants for the audio sample streamer: envelope states,
// sample/channel widths and the full-scale gain helper.
package audio_stream_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CHAN_W   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_e;

  // Unity gain for a gain register with gain_w fraction bits.
  function automatic int gain_full(input int gain_w);
    return 32'sd1 <<< gain_w;
  endfunction

endpackage

// File: rtl/audio_sample_streamer_if.sv
// Sample-input handshake and codec-output bus of the streamer; the generator
// and controller side uses master, the streamer uses slave.
interface audio_sample_streamer_if;
  import audio_stream_pkg::*;

  logic [SAMPLE_W-1:0] In_Sample;
  logic                In_Valid;
  logic                In_Ready;
  logic                Audio_Out_Allowed;
  logic                Write_Audio_Out;
  logic [CHAN_W-1:0]   Left_Out;
  logic [CHAN_W-1:0]   Right_Out;

  modport master (
    output In_Sample, In_Valid, Audio_Out_Allowed,
    input  In_Ready, Write_Audio_Out, Left_Out, Right_Out
  );

  modport slave (
    input  In_Sample, In_Valid, Audio_Out_Allowed,
    output In_Ready, Write_Audio_Out, Left_Out, Right_Out
  );

endinterface

// File: rtl/audio_sample_streamer_fifo.sv
// First-word-fall-through sample FIFO; flush empties it and overrides any
// push or pop issued in the same cycle.
module sample_fifo
  import audio_stream_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [SAMPLE_W-1:0] push_data,
  output logic [SAMPLE_W-1:0] pop_data,
  output logic                full,
  output logic                empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

  logic [SAMPLE_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W:0]      count_r;
  logic                do_push_s;
  logic                do_pop_s;

  // Status flags and qualified push/pop.
  always_comb begin
    full      = (count_r == COUNT_FULL);
    empty     = (count_r == '0);
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    pop_data  = mem_r[rd_ptr_r];
  end

  // Sample storage.
  always_ff @(posedge Clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_streamer.sv
// Buffers generator samples, applies a click-free attack/release envelope gated
// by Play, and feeds stereo words to the codec controller one write at a time.
module audio_sample_streamer
  import audio_stream_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Play,
  audio_sample_streamer_if.slave  bus,
  output logic [15:0]             Underrun_Count,
  output logic                    Active
);

  localparam logic [GAIN_W:0]   GAIN_FULL = (GAIN_W+1)'(gain_full(GAIN_W));
  localparam logic [GAIN_W+1:0] FULL_X    = {1'b0, GAIN_FULL};
  localparam logic [GAIN_W+1:0] STEP_X    = (GAIN_W+2)'(RAMP_STEP);

  env_state_e                      state_r;
  env_state_e                      state_next_s;
  logic [GAIN_W:0]                 gain_r;
  logic [GAIN_W:0]                 gain_next_s;
  logic [GAIN_W:0]                 ramp_up_s;
  logic [GAIN_W:0]                 ramp_dn_s;
  logic [GAIN_W+1:0]               gain_ext_s;
  logic [GAIN_W+1:0]               up_sum_s;
  logic                            write_s;
  logic                            push_s;
  logic                            pop_s;
  logic                            flush_s;
  logic                            fifo_full_s;
  logic                            fifo_empty_s;
  logic [SAMPLE_W-1:0]             head_s;
  logic signed [SAMPLE_W+GAIN_W+1:0] product_s;
  logic [SAMPLE_W-1:0]             scaled_s;
  logic [SAMPLE_W-1:0]             out_word_r;
  logic [15:0]                     underrun_r;
  logic                            active_r;

  // Handshake strobes; both are forced low while reset is held.
  always_comb begin
    write_s             = bus.Audio_Out_Allowed & ~Reset;
    bus.Write_Audio_Out = write_s;
    bus.In_Ready        = ~fifo_full_s & ~Reset;
    push_s              = bus.In_Valid & bus.In_Ready;
    pop_s               = write_s & (state_r != IDLE) & ~fifo_empty_s;
  end

  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (push_s),
    .pop       (pop_s),
    .flush     (flush_s),
    .push_data (bus.In_Sample),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Saturating ramp candidates, computed one bit wider so the step cannot wrap.
  always_comb begin
    gain_ext_s = {1'b0, gain_r};
    up_sum_s   = gain_ext_s + STEP_X;
    if (up_sum_s >= FULL_X) begin
      ramp_up_s = GAIN_FULL;
    end else begin
      ramp_up_s = (GAIN_W+1)'(up_sum_s);
    end
    if (gain_ext_s <= STEP_X) begin
      ramp_dn_s = '0;
    end else begin
      ramp_dn_s = (GAIN_W+1)'(gain_ext_s - STEP_X);
    end
  end

  // Signed sample times unsigned gain; taking the bits above the fraction is a floor shift.
  always_comb begin
    product_s = $signed(head_s) * $signed({1'b0, gain_r});
    scaled_s  = SAMPLE_W'(product_s >>> GAIN_W);
  end

  // Envelope next state; a Play change wins over the ramp step in the same cycle.
  always_comb begin
    state_next_s = state_r;
    gain_next_s  = gain_r;
    flush_s      = 1'b0;
    case (state_r)
      IDLE: begin
        gain_next_s = '0;
        if (Play) state_next_s = ATTACK;
        else      state_next_s = IDLE;
      end
      ATTACK: begin
        if (!Play) begin
          state_next_s = RELEASE;
        end else if (write_s) begin
          gain_next_s = ramp_up_s;
          if (ramp_up_s == GAIN_FULL) state_next_s = SUSTAIN;
          else                        state_next_s = ATTACK;
        end else begin
          state_next_s = ATTACK;
        end
      end
      SUSTAIN: begin
        gain_next_s = GAIN_FULL;
        if (!Play) state_next_s = RELEASE;
        else       state_next_s = SUSTAIN;
      end
      RELEASE: begin
        if (Play) begin
          state_next_s = ATTACK;
        end else if (write_s) begin
          gain_next_s = ramp_dn_s;
          if (ramp_dn_s == '0) begin
            state_next_s = IDLE;
            flush_s      = 1'b1;
          end else begin
            state_next_s = RELEASE;
          end
        end else begin
          state_next_s = RELEASE;
        end
      end
      default: begin
        state_next_s = IDLE;
        gain_next_s  = '0;
      end
    endcase
  end

  // Envelope state, output word and starvation counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      gain_r     <= '0;
      out_word_r <= '0;
      underrun_r <= '0;
      active_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      gain_r   <= gain_next_s;
      active_r <= (state_next_s != IDLE);
      if (write_s) begin
        if (state_r != IDLE && !fifo_empty_s) begin
          out_word_r <= scaled_s;
        end else begin
          out_word_r <= '0;
        end
        if (state_r != IDLE && fifo_empty_s && underrun_r != 16'hFFFF) begin
          underrun_r <= underrun_r + 16'd1;
        end
      end
    end
  end

  assign bus.Left_Out    = {out_word_r, 16'h0000};
  assign bus.Right_Out   = {out_word_r, 16'h0000};
  assign Underrun_Count  = underrun_r;
  assign Active          = active_r;

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Bench for audio_sample_streamer: directed envelope scenarios plus random
// traffic, all checked against a queue-based reference of the streamer rules.
module tb_audio_sample_streamer;

  localparam int DEPTH  = 8;
  localparam int GAIN_W = 8;
  localparam int STEP   = 64;
  localparam int FULL   = 256;

  localparam int M_IDLE    = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_SUSTAIN = 2;
  localparam int M_RELEASE = 3;

  logic        Clock;
  logic        Reset;
  logic        Play;
  logic [15:0] Underrun_Count;
  logic        Active;

  audio_sample_streamer_if bus ();

  audio_sample_streamer #(
    .DEPTH     (DEPTH),
    .GAIN_W    (GAIN_W),
    .RAMP_STEP (STEP)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Play           (Play),
    .bus            (bus),
    .Underrun_Count (Underrun_Count),
    .Active         (Active)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: queued samples, gain, envelope mode, presented word, underruns.
  int m_q[$];
  int m_gain;
  int m_mode;
  int m_word;
  int m_under;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic int floor_scale(input int s, input int g);
    int p;
    int q;
    p = s * g;
    q = p / FULL;
    if (p < 0 && q * FULL != p) q = q - 1;
    return q;
  endfunction

  function automatic logic [31:0] word32(input int w);
    logic [15:0] lo;
    lo = 16'(w);
    return {lo, 16'h0000};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_gain  = 0;
    m_mode  = M_IDLE;
    m_word  = 0;
    m_under = 0;
  endtask

  task automatic model_step(input logic p, input logic v, input logic [15:0] s, input logic a);
    bit push;
    bit pop;
    bit flush;
    push  = v && (m_q.size() < DEPTH);
    pop   = 1'b0;
    flush = 1'b0;
    if (a) begin
      if (m_mode != M_IDLE && m_q.size() > 0) begin
        m_word = floor_scale(m_q[0], m_gain);
        pop = 1'b1;
      end else begin
        m_word = 0;
        if (m_mode != M_IDLE && m_under < 65535) m_under++;
      end
    end
    case (m_mode)
      M_IDLE: if (p) m_mode = M_ATTACK;
      M_ATTACK: begin
        if (!p) m_mode = M_RELEASE;
        else if (a) begin
          m_gain = (m_gain + STEP > FULL) ? FULL : m_gain + STEP;
          if (m_gain == FULL) m_mode = M_SUSTAIN;
        end
      end
      M_SUSTAIN: if (!p) m_mode = M_RELEASE;
      default: begin
        if (p) m_mode = M_ATTACK;
        else if (a) begin
          m_gain = (m_gain - STEP < 0) ? 0 : m_gain - STEP;
          if (m_gain == 0) begin
            m_mode = M_IDLE;
            flush  = 1'b1;
          end
        end
      end
    endcase
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(int'($signed(s)));
    if (flush) m_q.delete();
  endtask

  // One clock: drive at the falling edge, check strobes, step the model, check after the rise.
  task automatic cycle(input logic p, input logic v, input logic [15:0] s, input logic a);
    Play = p;
    bus.In_Valid = v;
    bus.In_Sample = s;
    bus.Audio_Out_Allowed = a;
    #1;
    check_eq("in_ready", 32'(bus.In_Ready), (m_q.size() < DEPTH) ? 32'd1 : 32'd0);
    check_eq("write_strobe", 32'(bus.Write_Audio_Out), 32'(a));
    model_step(p, v, s, a);
    @(posedge Clock);
    #1;
    check_eq("left_out", bus.Left_Out, word32(m_word));
    check_eq("right_out", bus.Right_Out, word32(m_word));
    check_eq("underrun", 32'(Underrun_Count), 32'(m_under));
    check_eq("active", 32'(Active), (m_mode != M_IDLE) ? 32'd1 : 32'd0);
    @(negedge Clock);
  endtask

  // Asserts reset at the current instant and checks the outputs clear before any edge.
  task automatic apply_reset();
    Reset = 1'b1;
    Play = 1'b0;
    bus.In_Valid = 1'b0;
    bus.In_Sample = 16'h0000;
    bus.Audio_Out_Allowed = 1'b1;
    #1;
    check_eq("rst_write", 32'(bus.Write_Audio_Out), 32'd0);
    check_eq("rst_in_ready", 32'(bus.In_Ready), 32'd0);
    check_eq("rst_left", bus.Left_Out, 32'd0);
    check_eq("rst_right", bus.Right_Out, 32'd0);
    check_eq("rst_underrun", 32'(Underrun_Count), 32'd0);
    check_eq("rst_active", 32'(Active), 32'd0);
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic prefill(input int n, input logic p, input logic [15:0] s);
    for (int i = 0; i < n; i++) cycle(p, 1'b1, s, 1'b0);
  endtask

  initial begin
    logic play_v;
    Reset = 1'b1;
    Play = 1'b0;
    bus.In_Valid = 1'b0;
    bus.In_Sample = 16'h0000;
    bus.Audio_Out_Allowed = 1'b0;
    model_reset();
    @(negedge Clock);
    apply_reset();

    // Idle with the controller always ready: zero words, no starvation.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("idle_left", bus.Left_Out, 32'd0);
    check_eq("idle_underrun", 32'(Underrun_Count), 32'd0);

    // Attack ramp from a prefilled FIFO, then sustain.
    apply_reset();
    prefill(8, 1'b0, 16'h4000);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 16'h0000, 1'b1);
      check_eq("attack_word", bus.Left_Out, 32'(i) * 32'h1000_0000);
    end
    // Negative sample at full gain, behind the three remaining 0x4000 samples.
    cycle(1'b1, 1'b1, 16'hC000, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    check_eq("neg_full", bus.Left_Out, 32'hC000_0000);

    // Negative sample at gain 64 floors to 0xF000.
    apply_reset();
    prefill(2, 1'b0, 16'hC000);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    check_eq("neg_gain64", bus.Left_Out, 32'hF000_0000);

    // Release with five queued samples: ramp down, flush, back to idle.
    apply_reset();
    prefill(8, 1'b0, 16'h4000);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b1, 16'h4000, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b1);
      check_eq("release_word", bus.Left_Out, 32'(4 - i) * 32'h1000_0000);
    end
    check_eq("release_idle", 32'(Active), 32'd0);
    check_eq("release_ready", 32'(bus.In_Ready), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("release_after", bus.Left_Out, 32'd0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    check_eq("flushed_empty", 32'(Underrun_Count), 32'd1);

    // Starvation in sustain.
    apply_reset();
    prefill(4, 1'b0, 16'h4000);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    check_eq("underrun3", 32'(Underrun_Count), 32'd3);
    check_eq("underrun_word", bus.Left_Out, 32'd0);

    // Full FIFO, push+pop at seven, then asynchronous reset mid-write.
    apply_reset();
    prefill(8, 1'b0, 16'h1234);
    check_eq("full_ready", 32'(bus.In_Ready), 32'd0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b1, 16'h5678, 1'b1);
    check_eq("count7_ready", 32'(bus.In_Ready), 32'd1);
    cycle(1'b1, 1'b1, 16'h0ABC, 1'b0);
    check_eq("count8_ready", 32'(bus.In_Ready), 32'd0);
    Play = 1'b1;
    bus.Audio_Out_Allowed = 1'b1;
    #3;
    apply_reset();

    // Random traffic against the reference.
    play_v = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) play_v = ~play_v;
      if (i == 1700) begin
        #4;
        apply_reset();
      end
      cycle(play_v, ($urandom_range(0, 9) < ((i < 1500) ? 7 : 4)), 16'($urandom),
            1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/audio_sample_streamer.md
# audio_sample_streamer

Buffers 16-bit signed samples from the tone generator in a small FIFO, applies a click-free attack/release gain envelope gated by the playback-enable line, and drives the left/right channel words and write strobe of the audio controller. It sits between the audio generator and the codec controller, replacing the bare `{Out, 16'b0}` register path. The underrun counter gives the bench and the board a visible measure of starvation.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `GAIN_W`, 8: gain fraction bits; full gain is 2^GAIN_W.
- `RAMP_STEP`, 1: gain increment or decrement per write.
- `Clock` in 1: 50 MHz system clock.
- `Reset` in 1: asynchronous, active-high reset.
- `Play` in 1: playback enable from the loop counter; level-sensitive.
- `In_Sample` in 16: signed sample from the generator.
- `In_Valid` in 1: `In_Sample` is valid.
- `In_Ready` out 1: FIFO can accept a sample.
- `Audio_Out_Allowed` in 1: the controller has room for one stereo word.
- `Write_Audio_Out` out 1: the stereo word is written this cycle.
- `Left_Out` out 32: `{scaled, 16'b0}`.
- `Right_Out` out 32: identical to `Left_Out`.
- `Underrun_Count` out 16: saturating count of starved writes.
- `Active` out 1: state is not IDLE.

## Operation
- **Push:** a sample is pushed when `In_Valid & In_Ready`.
  - `In_Ready` = `!full & !Reset`.
  - It does not account for a pop in the same cycle.
  - A simultaneous push and pop leaves the count unchanged.
- **Write cycle:** `Write_Audio_Out` = `Audio_Out_Allowed & !Reset`, combinational. Each such cycle is a "write cycle".
- **Output register:** `Left_Out`/`Right_Out` come from an output register. The register reloads on every write cycle, so the word presented is the one computed at the previous write.
- **Reload on a write cycle:**
  - In IDLE, load zero and do not pop.
  - In any other state with the FIFO non-empty, pop the head and load `scaled`.
  - In any other state with the FIFO empty, load zero and increment `Underrun_Count`, saturating at 0xFFFF.
- **Scaling:** `scaled` = (`In_Sample` × gain) >>> `GAIN_W`.
  - Signed 16 × unsigned (`GAIN_W`+1)-bit multiply with an arithmetic shift, truncating toward −∞.
  - Gain equal to 2^GAIN_W passes the sample exactly.
  - The result always fits in 16 bits.
- **Envelope FSM** (held in a `GAIN_W`+1-bit gain register):
  - IDLE:
    - gain = 0.
    - `Play`=1 goes to ATTACK.
    - The FIFO prefills; there are no pops.
  - ATTACK:
    - Each write cycle, gain = min(gain+`RAMP_STEP`, full).
    - Reaching full goes to SUSTAIN.
    - `Play`=0 goes to RELEASE, keeping the current gain.
  - SUSTAIN:
    - gain = full.
    - `Play`=0 goes to RELEASE.
  - RELEASE:
    - Each write cycle, gain = max(gain−`RAMP_STEP`, 0).
    - Reaching 0 goes to IDLE, and the FIFO is flushed in the same cycle.
    - `Play`=1 goes back to ATTACK from the current gain.
- **Scaling uses the pre-update gain.** The gain used to scale a write cycle's sample is the value before that cycle's update.
- **`Play` priority:** a `Play` change is evaluated every cycle. It takes priority over the ramp step in the same cycle, and no gain change occurs in that cycle.

## Timing
- **Reset values:**
  - `Left_Out` = `Right_Out` = 0.
  - `Underrun_Count` = 0.
  - `Active` = 0.
  - `In_Ready` = 0 while reset is asserted.
  - `Write_Audio_Out` = 0.
  - FSM in IDLE, gain = 0, FIFO empty.
- **Reset mid-operation:** reset clears everything immediately, discarding all buffered data.
- **Latency:** a sample popped at write N appears on the outputs from the cycle after write N until write N+1.
- **Consecutive writes:** back-to-back write cycles are legal, one pop per cycle.
- **Full FIFO:** with the FIFO full, `In_Ready`=0 and the generator must hold its sample.
- **Pointer wrap:** pointers wrap modulo `DEPTH`; the count is `clog2(DEPTH)+1` bits.
- **`Active`:** registered; it reflects the state after the clock edge.

## Structure
- **Package `audio_stream_pkg`:**
  - State enum `{IDLE, ATTACK, SUSTAIN, RELEASE}`.
  - `SAMPLE_W`=16 and `CHAN_W`=32.
  - Gain-full constant function of `GAIN_W`.
- **Sub-module `sample_fifo`:**
  - Parameterised `DEPTH` × 16 synchronous FIFO.
  - Ports: push, pop, data, `full`, `empty`, `flush`.
- **Top-level contents:** the FSM, gain register, multiplier, output register and underrun counter.

## Test plan
- **Reset, no traffic:** reset, then `Audio_Out_Allowed`=1 continuously with no `Play`. Expect `Write_Audio_Out`=1 every cycle, outputs 0, `Underrun_Count`=0, `Active`=0.
- **Attack ramp:** `RAMP_STEP`=64, prefill 8 × 0x4000, raise `Play`. Expect successive words 0x0000_0000, 0x1000_0000, 0x2000_0000, 0x3000_0000, then SUSTAIN with 0x4000_0000.
- **Negative sample:** in SUSTAIN, push 0xC000. Expect 0xC000_0000. At gain 64, push 0xC000 and expect 0xF000_0000.
- **Release and flush:** in SUSTAIN with 5 samples queued, drop `Play`. Expect gain stepping 256→192→128→64→0, then IDLE with the FIFO empty, `In_Ready`=1, and later words 0.
- **Underrun:** in SUSTAIN, stop pushing and issue 3 further writes with the FIFO empty. Expect `Underrun_Count`=3 and words 0.
- **Full FIFO and async reset:** fill to 8 and expect `In_Ready`=0. Do a simultaneous push and pop at count 7 and expect the count to stay 7. Assert reset asynchronously mid-write and expect all outputs 0 before the next edge.
